wand_bus_arbiter: RTL and testbench



---
 rtl/wand_arb_pkg.sv | 14 +
 rtl/wand_bus_node.sv | 23 ++
 rtl/wand_bus_arbiter.sv | 117 +++++++++++
 tb/tb_wand_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wand_arb_pkg.sv
// Shared constants for the wired-AND bus arbiter:
// FSM state encoding and default requester count / ID width.
package wand_arb_pkg;

  localparam int N_DEF   = 4;
  localparam int IDW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wand_bus_node.sv
// One requester's attachment to the wand line.
// Ports: contend_i (still in the round), req_i, id_bit_i (current ID bit),
//        line_i (resolved line), drv_o (wand driver), lost_o (lost this bit).
module wand_bus_node (
  input  logic contend_i,
  input  logic req_i,
  input  logic id_bit_i,
  input  logic line_i,
  output logic drv_o,
  output logic lost_o
);

  logic active;

  assign active = contend_i & req_i;

  // Inactive nodes sit recessive so they never disturb the line.
  assign drv_o  = active ? id_bit_i : 1'b1;

  // Recessive driven, dominant read back: someone with a lower ID is out there.
  assign lost_o = active & drv_o & ~line_i;

endmodule

// File: rtl/wand_bus_arbiter.sv
// Bitwise CAN-style arbiter: contenders drive IDs MSB-first onto a wand line,
// lowest ID wins; grant is held until the winner drops its request.
// Ports: clk, rst (async, active-high), req[N], id[N*IDW] (packed IDs),
//        grant[N] (one-hot, registered), busy, bus_line (resolved line).
module wand_bus_arbiter
  import wand_arb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = IDW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*IDW-1:0] id,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic             bus_line
);

  localparam int IW = (IDW > 1) ? $clog2(IDW) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(IDW - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  contend_q, contend_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic [N-1:0]  grant_q, grant_d;

  logic [N-1:0]  drv;
  logic [N-1:0]  lost;
  logic [N-1:0]  contend_upd;
  logic          in_arb;

  wand bus_w;

  assign in_arb = (state_q == ST_ARB);

  for (genvar i = 0; i < N; i++) begin : g_node
    logic [IDW-1:0] id_l;
    assign id_l = id[i*IDW +: IDW];

    wand_bus_node u_node (
      .contend_i (contend_q[i] & in_arb),
      .req_i     (req[i]),
      .id_bit_i  (id_l[bit_idx_q]),
      .line_i    (bus_w),
      .drv_o     (drv[i]),
      .lost_o    (lost[i])
    );

    assign bus_w = drv[i];
  end

  assign bus_line = bus_w;

  // Survivors after this bit: still requesting and not out-driven.
  assign contend_upd = contend_q & req & ~lost;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      contend_q <= '0;
      bit_idx_q <= IDX_TOP;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      contend_q <= contend_d;
      bit_idx_q <= bit_idx_d;
      grant_q   <= grant_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    contend_d = contend_q;
    bit_idx_d = bit_idx_q;
    grant_d   = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_ARB;
          contend_d = req;
          bit_idx_d = IDX_TOP;
        end
      end
      ST_ARB: begin
        contend_d = contend_upd;
        if (contend_upd == '0) begin
          state_d   = ST_IDLE;
          bit_idx_d = IDX_TOP;
        end else if (bit_idx_q == '0) begin
          state_d   = ST_GRANT;
          bit_idx_d = IDX_TOP;
          // Lowest set bit; only matters for duplicate IDs.
          grant_d   = contend_upd & (N'(0) - contend_upd);
        end else begin
          bit_idx_d = bit_idx_q - 1'b1;
        end
      end
      ST_GRANT: begin
        if ((req & grant_q) == '0) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    grant = grant_q;
  end

endmodule

// File: tb/tb_wand_bus_arbiter.sv
// Directed bench for wand_bus_arbiter with
// N=4, IDW=4, ids {C,5,3,9}.
module tb_wand_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] id;
  logic [3:0]  grant;
  logic        busy;
  logic        bus_line;

  int tests;
  int fails;

  wand_bus_arbiter #(.N(4), .IDW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .id       (id),
    .grant    (grant),
    .busy     (busy),
    .bus_line (bus_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    repeat (3) tick();
    tests++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    tests++;
    if (bus_line !== 1'b1) begin
      fails++;
      $display("FAIL reset_line got=%b exp=1", bus_line);
    end
    req = 4'b0000;
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single();
    logic [3:0] seq;
    seq = 4'b0101;
    req = 4'b0100;
    tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL single_busy got=%b exp=1", busy);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (bus_line !== seq[3-k]) begin
        fails++;
        $display("FAIL single_line%0d got=%b exp=%b",
                 k, bus_line, seq[3-k]);
      end
      tests++;
      if (grant !== 4'b0000) begin
        fails++;
        $display("FAIL single_early_grant%0d got=%b exp=0000", k, grant);
      end
      tick();
    end
    tests++;
    if (grant !== 4'b0100) begin
      fails++;
      $display("FAIL single_grant got=%b exp=0100", grant);
    end
    req = 4'b0000;
    tick();
    tests++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_release got=%b/%b exp=0000/0", grant, busy);
    end
  endtask

  task automatic test_all_four();
    logic [3:0] seq;
    seq = 4'b0011;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (bus_line !== seq[3-k]) begin
        fails++;
        $display("FAIL all_line%0d got=%b exp=%b",
                 k, bus_line, seq[3-k]);
      end
      tick();
    end
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL all_grant got=%b exp=0010", grant);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_withdraw();
    req = 4'b0110;
    tick();
    tests++;
    if (bus_line !== 1'b0) begin
      fails++;
      $display("FAIL wd_line0 got=%b exp=0", bus_line);
    end
    tick();
    req = 4'b0100;
    #1;
    tests++;
    if (bus_line !== 1'b1) begin
      fails++;
      $display("FAIL wd_line1 got=%b exp=1", bus_line);
    end
    repeat (3) tick();
    tests++;
    if (grant !== 4'b0100) begin
      fails++;
      $display("FAIL wd_grant got=%b exp=0100", grant);
    end
    req = 4'b0000;
    tick();
    req = 4'b0110;
    tick();
    tick();
    req = 4'b0000;
    tick();
    tests++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      fails++;
      $display("FAIL wd_all_drop got=%b/%b exp=0/0000", busy, grant);
    end
    repeat (3) tick();
    tests++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("FAIL wd_no_grant got=%b exp=0000", grant);
    end
  endtask

  task automatic test_release();
    req = 4'b1010;
    repeat (5) tick();
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (grant !== 4'b0010) begin
        fails++;
        $display("FAIL rel_hold%0d got=%b exp=0010", k, grant);
      end
      tick();
    end
    req = 4'b1000;
    tick();
    tests++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rel_drop got=%b/%b exp=0000/0", grant, busy);
    end
    tick();
    tests++;
    if (busy !== 1'b1 || grant !== 4'b0000) begin
      fails++;
      $display("FAIL rel_rearb got=%b/%b exp=1/0000", busy, grant);
    end
    repeat (3) tick();
    tests++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("FAIL rel_early got=%b exp=0000", grant);
    end
    tick();
    tests++;
    if (grant !== 4'b1000) begin
      fails++;
      $display("FAIL rel_grant3 got=%b exp=1000", grant);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0110;
    tick();
    tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ar_pre_busy got=%b exp=1", busy);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      fails++;
      $display("FAIL ar_async got=%b/%b exp=0/0000", busy, grant);
    end
    tests++;
    if (bus_line !== 1'b1) begin
      fails++;
      $display("FAIL ar_line got=%b exp=1", bus_line);
    end
    #1 rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b1 || bus_line !== 1'b0) begin
      fails++;
      $display("FAIL ar_restart got=%b/%b exp=1/0", busy, bus_line);
    end
    repeat (3) tick();
    tests++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("FAIL ar_early got=%b exp=0000", grant);
    end
    tick();
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL ar_grant got=%b exp=0010", grant);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    id    = {4'hC, 4'h5, 4'h3, 4'h9};
    #1;
    test_reset();
    test_single();
    test_all_four();
    test_withdraw();
    test_release();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
